// File: rtl/small_poly_encoder.sv
// small_poly_encoder
//   Packs a stream of ternary coefficients {-1,0,+1} into Small-encoded bytes.
//   Each coefficient c becomes the 2-bit code c+1. Four codes go into one byte,
//   LSB-first, so coefficient 0 of a byte sits in bits [1:0]. One polynomial
//   of P coefficients produces ceil(P/4) bytes. Unused pairs in the final
//   partial byte read as zero.
//
//   Optional build macro: COEF_RANGE_CHECK_EN. When it is defined, an accepted
//   coefficient outside {0, 1, all-ones} sets the sticky err flag and is
//   encoded as zero. When it is not defined, err is tied low and the code is
//   formed from coef_in[1:0] alone.
//
//   Ports
//     clk, rst_n          rising-edge clock, asynchronous active-low reset
//     start               begins a polynomial; ignored unless idle
//     coef_in/valid/ready coefficient input stream
//     byte_out/valid/ready/last  packed byte output stream; last marks the
//                         byte that holds coefficient P-1
//     busy                high whenever a frame is in progress
//     done                one-cycle pulse after the final byte handshake
//     err                 sticky illegal-coefficient flag, cleared by start
//
//   Handshake semantics (both streams): a transfer happens on a rising edge
//   where valid and ready are both high. Once byte_valid is high, byte_out and
//   byte_last hold until that transfer. coef_ready is only high while packing
//   and the output register is empty or being emptied on the same edge.
module small_poly_encoder #(
  parameter int P  = 757,
  parameter int CW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] coef_in,
  input  logic          coef_valid,
  output logic          coef_ready,
  output logic [7:0]    byte_out,
  output logic          byte_valid,
  input  logic          byte_ready,
  output logic          byte_last,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int NBYTES = (P + 3) / 4;
  localparam int CNT_W  = (P > 1) ? $clog2(P) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(P - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] coef_cnt_q, coef_cnt_d;
  logic [1:0]       slot_q, slot_d;
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       byte_out_q, byte_out_d;
  logic             byte_valid_q, byte_valid_d;
  logic             byte_last_q, byte_last_d;
  logic             done_q, done_d;

  logic       coef_fire;
  logic       byte_fire;
  logic       last_coef;
  logic [1:0] code;
  logic [7:0] merged;

  assign coef_ready = (state_q == ST_PACK) && (!byte_valid_q || byte_ready);
  assign coef_fire  = coef_valid && coef_ready;
  assign byte_fire  = byte_valid_q && byte_ready;
  assign last_coef  = (coef_cnt_q == LAST_IDX);

`ifdef COEF_RANGE_CHECK_EN
  logic err_q, err_d;
  logic coef_legal;

  assign coef_legal = (coef_in == '0) || (coef_in == CW'(1)) || (coef_in == '1);
  // Illegal values are folded onto the zero code so the frame stays well formed.
  assign code = coef_legal ? (coef_in[1:0] + 2'b01) : 2'b01;
  assign err  = err_q;
`else
  logic unused_coef_hi;

  assign unused_coef_hi = ^coef_in[CW-1:2];
  assign code = coef_in[1:0] + 2'b01;
  assign err  = 1'b0;
`endif

  // Accumulated byte with the incoming code placed in its slot.
  assign merged = acc_q | ({6'b0, code} << {slot_q, 1'b0});

  always_comb begin
    state_d      = state_q;
    coef_cnt_d   = coef_cnt_q;
    slot_d       = slot_q;
    acc_d        = acc_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = byte_valid_q;
    byte_last_d  = byte_last_q;
    done_d       = 1'b0;
`ifdef COEF_RANGE_CHECK_EN
    err_d        = err_q;
`endif

    // Output register empties on handshake; a load below overrides this.
    if (byte_fire) begin
      byte_valid_d = 1'b0;
      byte_last_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_PACK;
          coef_cnt_d = '0;
          slot_d     = 2'd0;
          acc_d      = 8'h00;
`ifdef COEF_RANGE_CHECK_EN
          err_d      = 1'b0;
`endif
        end
      end
      ST_PACK: begin
        if (coef_fire) begin
`ifdef COEF_RANGE_CHECK_EN
          if (!coef_legal) err_d = 1'b1;
`endif
          coef_cnt_d = coef_cnt_q + CNT_W'(1);
          if ((slot_q == 2'd3) || last_coef) begin
            // Byte complete (or polynomial ends mid-byte): move it out.
            byte_out_d   = merged;
            byte_valid_d = 1'b1;
            byte_last_d  = last_coef;
            acc_d        = 8'h00;
            slot_d       = 2'd0;
          end else begin
            acc_d  = merged;
            slot_d = slot_q + 2'd1;
          end
          if (last_coef) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (byte_fire && byte_last_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      coef_cnt_q   <= '0;
      slot_q       <= 2'd0;
      acc_q        <= 8'h00;
      byte_out_q   <= 8'h00;
      byte_valid_q <= 1'b0;
      byte_last_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      coef_cnt_q   <= coef_cnt_d;
      slot_q       <= slot_d;
      acc_q        <= acc_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      byte_last_q  <= byte_last_d;
      done_q       <= done_d;
    end
  end

`ifdef COEF_RANGE_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`endif

  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign byte_last  = byte_last_q;
  assign done       = done_q;
  assign busy       = (state_q != ST_IDLE);

  // Frame length sanity for anyone reading the parameters.
  if (NBYTES < 1) begin : g_bad_p
    $error("small_poly_encoder needs P >= 1");
  end

endmodule

// File: tb/tb_small_poly_encoder.sv
// Testbench for small_poly_encoder. The expected byte stream of each frame is
// computed from the coefficient list with plain arithmetic (c+1 per
// coefficient, four per byte, LSB first) and queued; one negedge process
// checks every byte handshake, reset values, stalls and output latency.
module tb_small_poly_encoder;

  localparam int P  = 757;
  localparam int CW = 13;
  localparam int NB = (P + 3) / 4;
  localparam int BUDGET = 4000;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] coef_in;
  logic          coef_valid;
  logic          coef_ready;
  logic [7:0]    byte_out;
  logic          byte_valid;
  logic          byte_ready;
  logic          byte_last;
  logic          busy;
  logic          done;
  logic          err;

  small_poly_encoder #(.P(P), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .coef_in    (coef_in),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_last  (byte_last),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [7:0]    exp_q[$];
  logic [CW-1:0] coefs [P];
  int n_cmp = 0;
  int n_err = 0;
  int rx_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Small encoding of one coefficient, from its numeric value.
  function automatic logic [1:0] code_of(input logic [CW-1:0] c);
    int v;
    if (c == 0) v = 0;
    else if (c == 1) v = 1;
    else if (c == {CW{1'b1}}) v = -1;
    else begin
`ifdef COEF_RANGE_CHECK_EN
      v = 0;
`else
      return c[1:0] + 2'd1;
`endif
    end
    return 2'(v + 1);
  endfunction

  function automatic logic [CW-1:0] tern(input int v);
    return (v < 0) ? {CW{1'b1}} : CW'(v);
  endfunction

  // Fill coefs for a pattern and build the expected byte queue.
  task automatic build_model(input int kind);
    int pat[4];
    int b;
    pat = '{1, -1, 0, 1};
    for (int i = 0; i < P; i++) begin
      case (kind)
        0: coefs[i] = tern(0);
        1: coefs[i] = tern(pat[i % 4]);
        2: coefs[i] = tern(((i * i + i / 5) % 3) - 1);
        default: coefs[i] = (i == 0) ? CW'(5) : tern(0);
      endcase
    end
    exp_q.delete();
    for (b = 0; b < NB; b++) begin
      int v;
      v = 0;
      for (int k = 0; k < 4; k++)
        if (4 * b + k < P) v += int'(code_of(coefs[4 * b + k])) * (1 << (2 * k));
      exp_q.push_back(8'(v));
    end
  endtask

  // ---------------- compare process ----------------
  int   acc_cnt = 0;
  bit   bv_due = 0;
  bit   prev_stall = 0;
  logic [7:0] prev_out;
  logic prev_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_coef_ready", coef_ready, 0);
      check("rst_byte_valid", byte_valid, 0);
      check("rst_byte_last", byte_last, 0);
      check("rst_byte_out", byte_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      acc_cnt = 0;
      bv_due = 0;
      prev_stall = 0;
    end else begin
      if (bv_due) check("byte_valid_latency", byte_valid, 1);
      if (prev_stall) begin
        check("stall_valid_held", byte_valid, 1);
        check("stall_out_stable", byte_out, prev_out);
        check("stall_last_stable", byte_last, prev_last);
      end
      if (!busy) check("coef_ready_idle", coef_ready, 0);
      if (byte_valid && !byte_ready) check("coef_ready_stall", coef_ready, 0);
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) check("unexpected_byte", 1, 0);
        else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("byte_out", byte_out, e);
          check("byte_last", byte_last, exp_q.size() == 0);
          rx_cnt++;
        end
      end
      if (done) done_cnt++;
      bv_due = 0;
      if (start && !busy) acc_cnt = 0;
      if (coef_valid && coef_ready) begin
        if ((acc_cnt % 4 == 3) || (acc_cnt == P - 1)) bv_due = 1;
        acc_cnt++;
      end
      prev_stall = byte_valid && !byte_ready;
      prev_out   = byte_out;
      prev_last  = byte_last;
    end
  end

  // ---------------- driver ----------------
  task automatic run_frame(input int kind, input int stall_at, input int abort_after,
                           input bit poke_start);
    int i;
    int cyc;
    bit fin;
    build_model(kind);
    rx_cnt = 0;
    done_cnt = 0;
    @(posedge clk); #2;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, 1);
    @(posedge clk); #2;
    i = 0;
    cyc = 0;
    fin = 0;
    while (!fin && cyc < BUDGET) begin
      byte_ready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5);
      start = poke_start && (cyc == 50);
      if (abort_after >= 0 && i == abort_after) begin
        coef_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        exp_q.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        return;
      end
      coef_valid = (i < P);
      coef_in = (i < P) ? coefs[i] : '0;
      @(negedge clk);
      if (coef_valid && coef_ready) i++;
      if (done) fin = 1;
      @(posedge clk); #2;
      cyc++;
    end
    coef_valid = 1'b0;
    start = 1'b0;
    byte_ready = 1'b1;
    check("frame_timeout", cyc < BUDGET, 1);
    repeat (3) @(posedge clk);
    #2;
    check("coef_transfers", i, P);
    check("byte_count", rx_cnt, NB);
    check("exp_q_empty", exp_q.size(), 0);
    check("done_pulses", done_cnt, 1);
    check("busy_after_done", busy, 0);
  endtask

  // ---------------- main ----------------
  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    coef_in = '0;
    coef_valid = 1'b0;
    byte_ready = 1'b1;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Pin the model against hand-computed bytes.
    build_model(0);
    check("model_size", exp_q.size(), 190);
    check("model_zero_byte", exp_q[0], 8'h55);
    check("model_zero_last", exp_q[NB - 1], 8'h01);
    build_model(1);
    check("model_pat_byte", exp_q[5], 8'h92);
    check("model_pat_last", exp_q[NB - 1], 8'h02);

    // coef_valid while idle must never be accepted.
    coef_valid = 1'b1;
    coef_in = 13'h0001;
    repeat (5) @(posedge clk);
    #2 coef_valid = 1'b0;

    run_frame(0, -1, -1, 0);          // all zeros
    run_frame(1, 200, -1, 1);         // +1,-1,0,+1 with a 5-cycle stall and a stray start
    run_frame(2, -1, 100, 0);         // aborted by reset after 100 coefficients
    run_frame(2, 333, -1, 0);         // full mixed frame after the abort

    build_model(3);
`ifdef COEF_RANGE_CHECK_EN
    check("model_illegal_byte", exp_q[0], 8'h55);
`else
    check("model_illegal_byte", exp_q[0], 8'h56);
`endif
    run_frame(3, -1, -1, 0);
`ifdef COEF_RANGE_CHECK_EN
    check("err_sticky", err, 1);
`else
    check("err_tied_low", err, 0);
`endif
    run_frame(0, -1, -1, 0);
    check("err_cleared", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
